// File: rtl/multicycle_controller.sv
`default_nettype none
//==============================================================================
// Module   : multicycle_controller
// Purpose  : Moore FSM that sequences fetch/decode/execute/memory/writeback
//            for a multicycle RV32I datapath. It drives the datapath enables
//            and mux selects, handles memory ready handshakes, and latches a
//            sticky trap on illegal instructions.
// Revision : 1.0 - initial release
//==============================================================================
module multicycle_controller #(
    parameter int ALU_CTRL_W = 3,
    parameter bit ENABLE_EXT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op_code,
    input  logic [2:0]            func3,
    input  logic                  func7b6,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLL = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;
    localparam logic [2:0] c_ALU_SRL = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [2:0] w_alu;
    logic [2:0] w_alu_dec;
    logic       w_alu_ok;
    logic       w_br_ok;

    // func3 011/100 have no ALU operation; everything else maps to one.
    assign w_alu_ok = (func3 != 3'b011) && (func3 != 3'b100);

    // beq is always legal; bne/blt only with the extension enabled.
    assign w_br_ok  = (func3 == 3'b000) ||
                      (ENABLE_EXT && ((func3 == 3'b001) || (func3 == 3'b100)));

    // ALU operation for R/I-type execute; sub only for R-type with bit 30 set.
    always_comb begin
        w_alu_dec = c_ALU_ADD;
        case (func3)
            3'b000:  w_alu_dec = ((op_code == c_OP_R) && func7b6) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  w_alu_dec = c_ALU_SLL;
            3'b010:  w_alu_dec = c_ALU_SLT;
            3'b101:  w_alu_dec = c_ALU_SRL;
            3'b110:  w_alu_dec = c_ALU_OR;
            3'b111:  w_alu_dec = c_ALU_AND;
            default: w_alu_dec = c_ALU_ADD;
        endcase
    end

    // Immediate format is a pure function of the opcode.
    always_comb begin
        imm_src = 3'b000;
        case (op_code)
            c_OP_STORE: imm_src = 3'b001;
            c_OP_BR:    imm_src = 3'b010;
            c_OP_JAL:   imm_src = 3'b011;
            c_OP_LUI:   imm_src = 3'b100;
            default:    imm_src = 3'b000;
        endcase
    end

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        w_alu         = c_ALU_ADD;
        illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch/jal target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op_code)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_R:   w_next = w_alu_ok ? S_EXEC_R : S_TRAP;
                    c_OP_I:   w_next = w_alu_ok ? S_EXEC_I : S_TRAP;
                    c_OP_BR:  w_next = w_br_ok  ? S_BRANCH : S_TRAP;
                    c_OP_JAL: w_next = S_JAL;
                    c_OP_LUI: w_next = ENABLE_EXT ? S_LUI : S_TRAP;
                    default:  w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op_code == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                w_alu     = w_alu_dec;
                w_next    = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_alu     = w_alu_dec;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                // beq takes on zero; bne and blt (slt result nonzero) on !zero.
                alu_src_a  = 2'b10;
                w_alu      = (func3 == 3'b100) ? c_ALU_SLT : c_ALU_SUB;
                w_pc_write = (func3 == 3'b000) ? zero : ~zero;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                w_next    = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                w_next        = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Enables are suppressed whenever reset is asserted so nothing is written.
    assign pc_write    = w_pc_write  & ~rst;
    assign mem_write   = w_mem_write & ~rst;
    assign ir_write    = w_ir_write  & ~rst;
    assign reg_write   = w_reg_write & ~rst;
    assign alu_control = ALU_CTRL_W'(w_alu);
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed, table-driven bench for multicycle_controller plus
//            hand-written sequences for traps, extension disable and decode.
// Revision : 1.0 - initial release
//==============================================================================
module tb_multicycle_controller;

    localparam logic [6:0] c_R  = 7'b0110011;
    localparam logic [6:0] c_I  = 7'b0010011;
    localparam logic [6:0] c_LD = 7'b0000011;
    localparam logic [6:0] c_ST = 7'b0100011;
    localparam logic [6:0] c_BR = 7'b1100011;
    localparam logic [6:0] c_JL = 7'b1101111;
    localparam logic [6:0] c_LU = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_code;
    logic [2:0] func3;
    logic       func7b6;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    logic [3:0] state;

    logic       pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, illegal_instr0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0;
    logic [2:0] imm_src0;
    logic [3:0] alu_control0;
    logic [3:0] state0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ALU_CTRL_W(3), .ENABLE_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .func3(func3), .func7b6(func7b6),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr),
        .state(state)
    );

    multicycle_controller #(.ALU_CTRL_W(4), .ENABLE_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op_code(op_code), .func3(func3), .func7b6(func7b6),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write0), .adr_src(adr_src0),
        .mem_write(mem_write0), .ir_write(ir_write0), .reg_write(reg_write0),
        .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .imm_src(imm_src0), .alu_control(alu_control0), .illegal_instr(illegal_instr0),
        .state(state0)
    );

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       b30;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] rs;
        logic [2:0] alu;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(input logic r, input logic [6:0] op, input logic [2:0] f3,
                         input logic b30, input logic z, input logic mr,
                         input logic [3:0] st, input logic pcw, input logic irw,
                         input logic rw, input logic mw, input logic adr,
                         input logic [1:0] rs, input logic [2:0] alu, input logic ill);
        vec_t v;
        v.rst = r; v.op = op; v.f3 = f3; v.b30 = b30; v.z = z; v.mr = mr;
        v.st = st; v.pcw = pcw; v.irw = irw; v.rw = rw; v.mw = mw; v.adr = adr;
        v.rs = rs; v.alu = alu; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [14:0] w_obs, w_exp;
    logic [2:0]  alu_f3  [5];
    logic [2:0]  alu_exp [5];
    logic [6:0]  imm_op  [6];
    logic [2:0]  imm_exp [6];

    initial begin
        rst = 1'b1; op_code = c_R; func3 = 3'b000; func7b6 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        tick();

        // rst  op   f3   b  z  mr | st pcw irw rw mw adr rs alu ill
        add_v(1, c_R, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 2, 0, 0); // enables gated by rst
        add_v(0, c_R, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 2, 0, 0); // add
        add_v(0, c_R, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_R, 0, 0, 0, 1,   6, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_R, 0, 0, 0, 1,   8, 0, 0, 1, 0, 0, 0, 0, 0);
        add_v(0, c_R, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0, 2, 0, 0); // sub
        add_v(0, c_R, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_R, 0, 1, 0, 1,   6, 0, 0, 0, 0, 0, 0, 1, 0);
        add_v(0, c_R, 0, 1, 0, 1,   8, 0, 0, 1, 0, 0, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 0); // lw, fetch waits
        add_v(0, c_LD, 2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  3, 0, 0, 0, 0, 1, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  3, 0, 0, 0, 0, 1, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  3, 0, 0, 0, 0, 1, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 1,  3, 0, 0, 0, 0, 1, 0, 0, 0);
        add_v(0, c_LD, 2, 0, 0, 0,  4, 0, 0, 1, 0, 0, 1, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // sw
        add_v(0, c_ST, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 0,  5, 0, 0, 0, 1, 1, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 1,  5, 0, 0, 0, 1, 1, 0, 0, 0);
        add_v(0, c_BR, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // bne taken
        add_v(0, c_BR, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_BR, 1, 0, 0, 1,  9, 1, 0, 0, 0, 0, 0, 1, 0);
        add_v(0, c_BR, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // beq taken
        add_v(0, c_BR, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_BR, 0, 0, 1, 1,  9, 1, 0, 0, 0, 0, 0, 1, 0);
        add_v(0, c_BR, 1, 0, 1, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // bne not taken
        add_v(0, c_BR, 1, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_BR, 1, 0, 1, 1,  9, 0, 0, 0, 0, 0, 0, 1, 0);
        add_v(0, c_BR, 4, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // blt taken
        add_v(0, c_BR, 4, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_BR, 4, 0, 0, 1,  9, 1, 0, 0, 0, 0, 0, 5, 0);
        add_v(0, c_JL, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // jal
        add_v(0, c_JL, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_JL, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_JL, 0, 0, 0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0);
        add_v(0, c_I, 6, 0, 0, 1,   0, 1, 1, 0, 0, 0, 2, 0, 0); // ori
        add_v(0, c_I, 6, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_I, 6, 0, 0, 1,   7, 0, 0, 0, 0, 0, 0, 3, 0);
        add_v(0, c_I, 6, 0, 0, 1,   8, 0, 0, 1, 0, 0, 0, 0, 0);
        add_v(0, c_LU, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // lui
        add_v(0, c_LU, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_LU, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_LU, 0, 0, 0, 1,  8, 0, 0, 1, 0, 0, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 1,  0, 1, 1, 0, 0, 0, 2, 0, 0); // sw, reset mid-write
        add_v(0, c_ST, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 0,  5, 0, 0, 0, 1, 1, 0, 0, 0);
        add_v(1, c_ST, 2, 0, 0, 0,  5, 0, 0, 0, 0, 1, 0, 0, 0);
        add_v(1, c_ST, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 0);
        add_v(0, c_ST, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 0);
        add_v(0, c_R, 3, 0, 0, 1,   0, 1, 1, 0, 0, 0, 2, 0, 0); // illegal R func3
        add_v(0, c_R, 3, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, c_R, 3, 0, 0, 1,  12, 0, 0, 0, 0, 0, 0, 0, 1);
        add_v(0, c_R, 3, 0, 0, 0,  12, 0, 0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; op_code = vecs[i].op; func3 = vecs[i].f3;
            func7b6 = vecs[i].b30; zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            w_obs = {state, pc_write, ir_write, reg_write, mem_write, adr_src,
                     result_src, alu_control, illegal_instr};
            w_exp = {vecs[i].st, vecs[i].pcw, vecs[i].irw, vecs[i].rw, vecs[i].mw,
                     vecs[i].adr, vecs[i].rs, vecs[i].alu, vecs[i].ill};
            check($sformatf("vec[%0d] {st,pcw,irw,rw,mw,adr,rs,alu,ill}", i), 32'(w_obs), 32'(w_exp));
            tick();
        end

        // Unknown opcode traps and stays trapped until reset.
        do_reset();
        op_code = 7'b1111111; mem_ready = 1'b1;
        tick();
        check("bad_op decode state", 32'(state), 32'd1);
        tick();
        for (int k = 0; k < 10; k++) begin
            mem_ready = k[0];
            #1;
            check($sformatf("trap hold %0d {st,ill,en}", k),
                  32'({state, illegal_instr, pc_write, ir_write, reg_write, mem_write}),
                  32'({4'd12, 1'b1, 4'b0000}));
            tick();
        end
        do_reset();
        check("trap cleared by rst {st,ill}", 32'({state, illegal_instr}), 32'({4'd0, 1'b0}));

        // Extension disabled: lui and bne trap; beq still works.
        mem_ready = 1'b1; op_code = c_LU; func3 = 3'b000;
        tick(); tick();
        check("ext0 lui {st,ill}", 32'({state0, illegal_instr0}), 32'({4'd12, 1'b1}));
        check("ext1 lui state", 32'(state), 32'd11);
        do_reset();
        op_code = c_BR; func3 = 3'b001; zero = 1'b0;
        tick(); tick();
        check("ext0 bne state", 32'(state0), 32'd12);
        check("ext1 bne state", 32'(state), 32'd9);
        do_reset();
        op_code = c_BR; func3 = 3'b000; zero = 1'b1;
        tick(); tick();
        check("ext0 beq {st,pcw,alu4}", 32'({state0, pc_write0, alu_control0}),
              32'({4'd9, 1'b1, 4'b0001}));

        // I-type ALU decode; bit 30 set must not turn addi into sub.
        alu_f3[0] = 3'b001; alu_exp[0] = 3'b100;
        alu_f3[1] = 3'b010; alu_exp[1] = 3'b101;
        alu_f3[2] = 3'b101; alu_exp[2] = 3'b111;
        alu_f3[3] = 3'b111; alu_exp[3] = 3'b010;
        alu_f3[4] = 3'b000; alu_exp[4] = 3'b000;
        for (int k = 0; k < 5; k++) begin
            do_reset();
            op_code = c_I; func3 = alu_f3[k]; func7b6 = 1'b1;
            tick(); tick();
            check($sformatf("exec_i f3=%0d {st,alu}", alu_f3[k]),
                  32'({state, alu_control}), 32'({4'd7, alu_exp[k]}));
        end

        // Immediate format decode.
        imm_op[0] = c_I;  imm_exp[0] = 3'b000;
        imm_op[1] = c_ST; imm_exp[1] = 3'b001;
        imm_op[2] = c_BR; imm_exp[2] = 3'b010;
        imm_op[3] = c_JL; imm_exp[3] = 3'b011;
        imm_op[4] = c_LU; imm_exp[4] = 3'b100;
        imm_op[5] = c_LD; imm_exp[5] = 3'b000;
        for (int k = 0; k < 6; k++) begin
            op_code = imm_op[k];
            #1;
            check($sformatf("imm_src op=%b", imm_op[k]), 32'(imm_src), 32'(imm_exp[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle RV32I controller: one FSM sequences fetch, decode, execute, memory and writeback over several cycles, so one ALU and one unified memory serve the whole datapath.
- Adds a memory ready handshake, bne/blt/lui support, a parametrised ALU control width and a sticky illegal-instruction trap.
- Sits beside the multicycle datapath and drives its enables and mux selects.

Parameters:
ALU_CTRL_W, 3, alu_control width; encoding occupies bits [2:0], upper bits driven 0.
ENABLE_EXT, 1, 1 = bne/blt/lui legal; 0 = those decode as illegal.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
op_code  input  7  instruction [6:0], valid from DECODE onward
func3  input  3  instruction [14:12]
func7b6  input  1  instruction bit 30
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC register enable
adr_src  output  1  0 = PC, 1 = ALUOut as memory address
mem_write  output  1  memory write strobe
ir_write  output  1  instruction/OldPC register enable
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut, 01 read data, 10 ALU result
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op_code
alu_control  output  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 111 srl
illegal_instr  output  1  high while in TRAP
state  output  4  current state, for debug

Behaviour:
- Moore FSM with a 4-bit state register; all outputs decode from state (plus op_code/func3/zero where noted).
- Unlisted enables are 0, selects are 00, alu_control is add.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12.
- Reset: rst high at a clock edge -> state=FETCH next cycle. While rst is high, every enable output is forced 0. Reset mid-instruction abandons it with no write.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write and pc_write = mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI (only if ENABLE_EXT)
  - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: adr_src=1. Wait on mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held until mem_ready, then FETCH. Exactly one cycle with mem_write=1 and mem_ready=1.
- EXEC_R: alu_src_a=10, alu_src_b=00, ALU decode on func3, then ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, ALU decode on func3, then ALUWB.
- ALU decode by func3:
  - 000: sub only if op_code=0110011 and func7b6=1, else add
  - 001: sll
  - 010: slt
  - 101: srl
  - 110: or
  - 111: and
  - 011, 100: illegal; DECODE goes to TRAP instead of EXEC_R/EXEC_I
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, result_src=00, then FETCH.
  - func3 000 (beq): sub, pc_write=zero
  - func3 001 (bne): sub, pc_write=!zero
  - func3 100 (blt): slt, pc_write=!zero
  - any other func3, or bne/blt with ENABLE_EXT=0: DECODE goes to TRAP.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 (PC <- target), then ALUWB (rd <- OldPC+4).
- LUI: alu_src_a=11, alu_src_b=01, add, then ALUWB.
- TRAP: illegal_instr=1, all enables 0. Sticky until rst.
- Unused encodings 13-15 go to TRAP next cycle.
- mem_ready is ignored in states other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- rst high 2 cycles during MEMWRITE with mem_ready=0 -> mem_write=0 during reset; state=0 on release; no write issued.
- add (0110011, f3 000, b30 0), mem_ready=1 -> states 0,1,6,8,0; alu_control 000 in EXEC_R; reg_write=1 only in ALUWB.
- lw with mem_ready held low 3 cycles in MEMREAD -> state stays 3 for 3 cycles, then 4; reg_write=1 with result_src=01 for exactly 1 cycle.
- bne with zero=0 -> pc_write=1 in BRANCH. Repeat with zero=1 -> pc_write=0. beq with zero=1 -> pc_write=1.
- jal -> states 0,1,10,8,0; pc_write=1 in JAL; imm_src=011 in DECODE.
- op_code 0110111 with ENABLE_EXT=0, and op_code 1111111 -> state=12, illegal_instr=1 held 10 cycles until rst.
